// File: rtl/vip_pkg.sv
// Shared types and constants for the VIP Avalon-ST packetizer.
// Packet FSM states, VIP packet-type nibbles and pattern-select codes.
package vip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CTRL_HDR,
    ST_CTRL_DATA,
    ST_VID_HDR,
    ST_VID_DATA
  } pkt_state_t;

  localparam logic [3:0] VIP_TYPE_CTRL  = 4'hF;
  localparam logic [3:0] VIP_TYPE_VIDEO = 4'h0;

  localparam logic [2:0] PAT_STNDRT   = 3'd0;
  localparam logic [2:0] PAT_OFFSET   = 3'd1;
  localparam logic [2:0] PAT_GRAD     = 3'd2;
  localparam logic [2:0] PAT_ONECOLOR = 3'd3;
  localparam logic [2:0] PAT_IMAG     = 3'd4;

  // A control-packet symbol carries one nibble in its low half.
  function automatic logic [7:0] nib_sym(input logic [3:0] nib);
    return {4'h0, nib};
  endfunction

endpackage

// File: rtl/vip_skid_buffer.sv
// Two-entry skid buffer with registered output and registered input ready.
// Entry 0 drives the output directly; entry 1 absorbs a beat while the sink stalls.
module vip_skid_buffer #(
  parameter int W = 27
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic [W-1:0] r_data0, r_data1;
  logic         r_valid0, r_valid1, r_in_ready;
  logic         w_push, w_pop;
  logic [1:0]   w_cnt_next;

  assign w_push = in_valid_i & r_in_ready;
  assign w_pop  = r_valid0 & out_ready_i;

  always_comb begin
    w_cnt_next = {1'b0, r_valid0} + {1'b0, r_valid1} + {1'b0, w_push} - {1'b0, w_pop};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      // NOTE: data registers are reset too, because the beat they hold is a module output that must read 0 in reset.
      r_data0    <= '0;
      r_data1    <= '0;
      r_valid0   <= 1'b0;
      r_valid1   <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_in_ready <= (w_cnt_next < 2'd2);
      if (w_pop) begin
        if (r_valid1) begin
          r_data0 <= r_data1;
          if (w_push) r_data1 <= in_data_i;
          else        r_valid1 <= 1'b0;
        end else if (w_push) begin
          r_data0 <= in_data_i;
        end else begin
          r_valid0 <= 1'b0;
        end
      end else if (w_push) begin
        if (!r_valid0) begin
          r_data0  <= in_data_i;
          r_valid0 <= 1'b1;
        end else begin
          r_data1  <= in_data_i;
          r_valid1 <= 1'b1;
        end
      end
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_valid0;
  assign out_data_o  = r_data0;

endmodule

// File: rtl/vip_stream_packetizer.sv
// Wraps generator pixels into Intel VIP Avalon-ST video: one control packet
// then one video packet per frame, output through a 2-entry skid buffer.
module vip_stream_packetizer
  import vip_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int FRAME_CNT_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [2:0]            pattern_sel_i,
  input  logic [15:0]           width_i,
  input  logic [15:0]           height_i,
  input  logic [3:0]            interlaced_i,
  input  logic [DATA_WIDTH-1:0] data_stndrt_i,
  input  logic [DATA_WIDTH-1:0] data_offset_i,
  input  logic [DATA_WIDTH-1:0] data_grad_i,
  input  logic [DATA_WIDTH-1:0] data_onecolor_i,
  input  logic [DATA_WIDTH-1:0] data_imag_i,
  input  logic                  pix_valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] dout_data_o,
  output logic                  dout_valid_o,
  output logic                  dout_sop_o,
  output logic                  dout_eop_o,
  input  logic                  dout_ready_i,
  output logic                  frame_done_o,
  output logic                  busy_o
);

  localparam int PW = DATA_WIDTH + 3;

  pkt_state_t             r_state;
  logic [15:0]            r_width, r_height;
  logic [3:0]             r_interlace;
  logic [2:0]             r_sel;
  logic [1:0]             r_beat_idx;
  logic [FRAME_CNT_W-1:0] r_pix_cnt, r_pix_last;

  logic                  w_push_valid, w_push_sop, w_push_eop, w_push_tag, w_push_fire;
  logic [DATA_WIDTH-1:0] w_push_data, w_pix;
  logic [23:0]           w_ctrl_beat;
  logic                  w_skid_in_ready, w_out_valid;
  logic [PW-1:0]         w_out_payload;

  always_comb begin
    case (r_sel)
      PAT_STNDRT:   w_pix = data_stndrt_i;
      PAT_OFFSET:   w_pix = data_offset_i;
      PAT_GRAD:     w_pix = data_grad_i;
      PAT_ONECOLOR: w_pix = data_onecolor_i;
      PAT_IMAG:     w_pix = data_imag_i;
      default:      w_pix = '0;
    endcase
  end

  // Symbol 0 sits in bits [7:0], so each beat is packed {sym2, sym1, sym0}.
  always_comb begin
    case (r_beat_idx)
      2'd0:    w_ctrl_beat = {nib_sym(r_width[7:4]),   nib_sym(r_width[11:8]),   nib_sym(r_width[15:12])};
      2'd1:    w_ctrl_beat = {nib_sym(r_height[11:8]), nib_sym(r_height[15:12]), nib_sym(r_width[3:0])};
      default: w_ctrl_beat = {nib_sym(r_interlace),    nib_sym(r_height[3:0]),   nib_sym(r_height[7:4])};
    endcase
  end

  always_comb begin
    w_push_valid = 1'b0;
    w_push_data  = '0;
    w_push_sop   = 1'b0;
    w_push_eop   = 1'b0;
    w_push_tag   = 1'b0;
    case (r_state)
      ST_CTRL_HDR: begin
        w_push_valid = 1'b1;
        w_push_data  = DATA_WIDTH'(VIP_TYPE_CTRL);
        w_push_sop   = 1'b1;
      end
      ST_CTRL_DATA: begin
        w_push_valid = 1'b1;
        w_push_data  = DATA_WIDTH'(w_ctrl_beat);
        w_push_eop   = (r_beat_idx == 2'd2);
      end
      ST_VID_HDR: begin
        w_push_valid = 1'b1;
        w_push_data  = DATA_WIDTH'(VIP_TYPE_VIDEO);
        w_push_sop   = 1'b1;
        w_push_tag   = 1'b1;
      end
      ST_VID_DATA: begin
        w_push_valid = pix_valid_i;
        w_push_data  = w_pix;
        w_push_eop   = (r_pix_cnt == r_pix_last);
        w_push_tag   = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_push_fire = w_push_valid & w_skid_in_ready;
  assign ready_o     = (r_state == ST_VID_DATA) & w_skid_in_ready;
  assign busy_o      = (r_state != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= ST_IDLE;
      r_width     <= '0;
      r_height    <= '0;
      r_interlace <= '0;
      r_sel       <= '0;
      r_beat_idx  <= '0;
      r_pix_cnt   <= '0;
      r_pix_last  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable_i && width_i != 16'd0 && height_i != 16'd0) begin
            r_width     <= width_i;
            r_height    <= height_i;
            r_interlace <= interlaced_i;
            r_sel       <= pattern_sel_i;
            r_pix_last  <= FRAME_CNT_W'(width_i) * FRAME_CNT_W'(height_i) - FRAME_CNT_W'(1);
            r_state     <= ST_CTRL_HDR;
          end
        end
        ST_CTRL_HDR: if (w_push_fire) begin
          r_beat_idx <= 2'd0;
          r_state    <= ST_CTRL_DATA;
        end
        ST_CTRL_DATA: if (w_push_fire) begin
          if (r_beat_idx == 2'd2) r_state <= ST_VID_HDR;
          else                    r_beat_idx <= r_beat_idx + 2'd1;
        end
        ST_VID_HDR: if (w_push_fire) begin
          r_pix_cnt <= '0;
          r_state   <= ST_VID_DATA;
        end
        ST_VID_DATA: if (w_push_fire) begin
          if (r_pix_cnt == r_pix_last) r_state <= ST_IDLE;
          else                         r_pix_cnt <= r_pix_cnt + FRAME_CNT_W'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Payload layout: {video tag, sop, eop, data}; the tag keeps control eop from signalling frame end.
  vip_skid_buffer #(.W(PW)) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (w_push_valid),
    .in_ready_o  (w_skid_in_ready),
    .in_data_i   ({w_push_tag, w_push_sop, w_push_eop, w_push_data}),
    .out_valid_o (w_out_valid),
    .out_ready_i (dout_ready_i),
    .out_data_o  (w_out_payload)
  );

  assign dout_valid_o = w_out_valid;
  assign dout_data_o  = w_out_payload[DATA_WIDTH-1:0];
  assign dout_eop_o   = w_out_payload[DATA_WIDTH];
  assign dout_sop_o   = w_out_payload[DATA_WIDTH+1];
  assign frame_done_o = w_out_valid & dout_ready_i & w_out_payload[DATA_WIDTH] & w_out_payload[DATA_WIDTH+2];

endmodule

// File: tb/tb_vip_stream_packetizer.sv
// Directed bench for vip_stream_packetizer: framing, control nibbles,
// back-pressure, mid-frame input changes, reset and pattern selection.
module tb_vip_stream_packetizer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        enable_i = 1'b0;
  logic [2:0]  pattern_sel_i = 3'd0;
  logic [15:0] width_i = 16'd0;
  logic [15:0] height_i = 16'd0;
  logic [3:0]  interlaced_i = 4'd0;
  logic        pix_valid_i = 1'b0;
  logic        dout_ready_i = 1'b1;
  logic [23:0] data_stndrt_i, data_offset_i, data_grad_i, data_onecolor_i, data_imag_i;
  logic        ready_o, dout_valid_o, dout_sop_o, dout_eop_o, frame_done_o, busy_o;
  logic [23:0] dout_data_o;

  int          n_checks = 0;
  int          n_fail = 0;
  int          gen_idx = 0;
  logic        gen_clr = 1'b0;
  logic        gen_take = 1'b0;
  logic        bp_rand = 1'b0;
  logic [25:0] obs_q[$];
  logic [25:0] exp_q[$];
  int          fd_cnt = 0;
  int          fd_bad = 0;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [25:0] prev_beat = '0;

  always #5 clk_i = ~clk_i;

  vip_stream_packetizer dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .enable_i        (enable_i),
    .pattern_sel_i   (pattern_sel_i),
    .width_i         (width_i),
    .height_i        (height_i),
    .interlaced_i    (interlaced_i),
    .data_stndrt_i   (data_stndrt_i),
    .data_offset_i   (data_offset_i),
    .data_grad_i     (data_grad_i),
    .data_onecolor_i (data_onecolor_i),
    .data_imag_i     (data_imag_i),
    .pix_valid_i     (pix_valid_i),
    .ready_o         (ready_o),
    .dout_data_o     (dout_data_o),
    .dout_valid_o    (dout_valid_o),
    .dout_sop_o      (dout_sop_o),
    .dout_eop_o      (dout_eop_o),
    .dout_ready_i    (dout_ready_i),
    .frame_done_o    (frame_done_o),
    .busy_o          (busy_o)
  );

  // Pixel generator: each bus carries a distinct base plus the accepted-pixel index.
  assign data_stndrt_i   = 24'h100000 + 24'(gen_idx);
  assign data_offset_i   = 24'h200000 + 24'(gen_idx);
  assign data_grad_i     = 24'h300000 + 24'(gen_idx);
  assign data_onecolor_i = 24'h400000 + 24'(gen_idx);
  assign data_imag_i     = 24'h500000 + 24'(gen_idx);

  always @(negedge clk_i) gen_take = pix_valid_i & ready_o;

  always @(posedge clk_i) begin
    #2;
    if (gen_clr)       gen_idx = 0;
    else if (gen_take) gen_idx = gen_idx + 1;
  end

  always @(posedge clk_i) begin
    #3;
    dout_ready_i = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: records accepted beats, stall stability and frame_done pulses.
  always @(negedge clk_i) begin
    if (prev_stall && (!dout_valid_o || {dout_sop_o, dout_eop_o, dout_data_o} !== prev_beat))
      stall_viol = stall_viol + 1;
    prev_stall = dout_valid_o && !dout_ready_i;
    prev_beat  = {dout_sop_o, dout_eop_o, dout_data_o};
    if (dout_valid_o && dout_ready_i) obs_q.push_back({dout_sop_o, dout_eop_o, dout_data_o});
    if (frame_done_o) begin
      fd_cnt = fd_cnt + 1;
      if (!(dout_valid_o && dout_ready_i && dout_eop_o)) fd_bad = fd_bad + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [23:0] pix(input logic [2:0] sel, input int i);
    case (sel)
      3'd0:    return 24'h100000 + 24'(i);
      3'd1:    return 24'h200000 + 24'(i);
      3'd2:    return 24'h300000 + 24'(i);
      3'd3:    return 24'h400000 + 24'(i);
      3'd4:    return 24'h500000 + 24'(i);
      default: return 24'h000000;
    endcase
  endfunction

  task automatic add_ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
    exp_q.push_back({2'b10, 24'h00000F});
    exp_q.push_back({2'b00, 4'h0, w[7:4],  4'h0, w[11:8],  4'h0, w[15:12]});
    exp_q.push_back({2'b00, 4'h0, h[11:8], 4'h0, h[15:12], 4'h0, w[3:0]});
    exp_q.push_back({2'b01, 4'h0, il,      4'h0, h[3:0],   4'h0, h[7:4]});
    exp_q.push_back({2'b10, 24'h000000});
  endtask

  task automatic add_frame(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il,
                           input logic [2:0] sel, input int start);
    int n;
    add_ctrl(w, h, il);
    n = int'(w) * int'(h);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, (i == n - 1), pix(sel, start + i)});
  endtask

  task automatic compare(input string tag);
    check({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_all();
    gen_clr = 1'b1;
    tick();
    tick();
    gen_clr = 1'b0;
    obs_q.delete();
    exp_q.delete();
    fd_cnt = 0;
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!busy_o && n < 20) begin tick(); n++; end
    check({tag, "_start"}, 32'(busy_o), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((busy_o || dout_valid_o) && n < 3000) begin tick(); n++; end
    check({tag, "_done"}, 32'(busy_o || dout_valid_o), 32'd0);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] w, input logic [15:0] h,
                           input logic [3:0] il, input logic [2:0] sel);
    clear_all();
    width_i = w; height_i = h; interlaced_i = il; pattern_sel_i = sel;
    pix_valid_i = 1'b1;
    enable_i = 1'b1;
    wait_busy(tag);
    enable_i = 1'b0;
    wait_done(tag);
    add_frame(w, h, il, sel, 0);
    compare(tag);
    check({tag, "_fdone"}, 32'(fd_cnt), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(dout_valid_o), 32'd0);
    check({tag, "_sop_eop"}, {30'd0, dout_sop_o, dout_eop_o}, 32'd0);
    check({tag, "_data"}, 32'(dout_data_o), 32'd0);
    check({tag, "_busy_ready"}, {30'd0, busy_o, ready_o}, 32'd0);
    check({tag, "_fdone"}, 32'(frame_done_o), 32'd0);
  endtask

  initial begin
    logic any_busy, any_valid;
    int   n, gap;

    // Reset state
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_i = 1'b1;
    tick();

    // Handshake: W=4 H=2 stndrt, sink always ready; sop on beats 0/4, eop on 3/12
    run_frame("hs", 16'd4, 16'd2, 4'h0, 3'd0);

    // Control nibbles for 1920x1080, interlace 3; reset once the headers are out
    clear_all();
    pix_valid_i = 1'b0;
    width_i = 16'd1920; height_i = 16'd1080; interlaced_i = 4'h3; pattern_sel_i = 3'd0;
    enable_i = 1'b1;
    wait_busy("ctrl");
    enable_i = 1'b0;
    n = 0;
    while (obs_q.size() < 5 && n < 40) begin tick(); n++; end
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    add_ctrl(16'd1920, 16'd1080, 4'h3);
    compare("ctrl");

    // Random back-pressure, W=16 H=4 offset pattern
    bp_rand = 1'b1;
    stall_viol = 0;
    run_frame("bp", 16'd16, 16'd4, 4'h0, 3'd1);
    bp_rand = 1'b0;
    check("bp_stall_stable", 32'(stall_viol), 32'd0);

    // Width change during VID_DATA; back-to-back frames with a 1-cycle IDLE gap
    clear_all();
    width_i = 16'd4; height_i = 16'd2; interlaced_i = 4'h5; pattern_sel_i = 3'd2;
    pix_valid_i = 1'b1;
    enable_i = 1'b1;
    wait_busy("mid");
    n = 0;
    while (!ready_o && n < 40) begin tick(); n++; end
    check("mid_in_vid_data", 32'(ready_o), 32'd1);
    width_i = 16'd8;
    n = 0;
    while (busy_o && n < 100) begin tick(); n++; end
    gap = 0;
    while (!busy_o && gap < 10) begin gap++; tick(); end
    check("mid_idle_gap", 32'(gap), 32'd1);
    enable_i = 1'b0;
    wait_done("mid");
    add_frame(16'd4, 16'd2, 4'h5, 3'd2, 0);
    add_frame(16'd8, 16'd2, 4'h5, 3'd2, 8);
    compare("mid");
    check("mid_fdone", 32'(fd_cnt), 32'd2);

    // Reset during pixel 3 of the video packet, then a fresh frame
    clear_all();
    width_i = 16'd4; height_i = 16'd2; interlaced_i = 4'h0; pattern_sel_i = 3'd0;
    enable_i = 1'b1;
    wait_busy("rstmid");
    enable_i = 1'b0;
    n = 0;
    while (gen_idx < 3 && n < 40) begin tick(); n++; end
    rst_i = 1'b0;
    tick();
    check_reset_outputs("rstmid");
    rst_i = 1'b1;
    run_frame("rstmid_after", 16'd4, 16'd2, 4'h0, 3'd0);

    // Zero width or disabled: no frame starts
    width_i = 16'd0; height_i = 16'd2;
    enable_i = 1'b1;
    any_busy = 1'b0; any_valid = 1'b0;
    repeat (12) begin tick(); any_busy |= busy_o; any_valid |= dout_valid_o; end
    check("zero_w_idle", {30'd0, any_busy, any_valid}, 32'd0);
    width_i = 16'd4;
    enable_i = 1'b0;
    any_busy = 1'b0; any_valid = 1'b0;
    repeat (12) begin tick(); any_busy |= busy_o; any_valid |= dout_valid_o; end
    check("disabled_idle", {30'd0, any_busy, any_valid}, 32'd0);

    // Pattern select: imag bus, and an unused code giving black pixels
    run_frame("sel4", 16'd2, 16'd1, 4'h0, 3'd4);
    run_frame("sel6", 16'd2, 16'd1, 4'h0, 3'd6);

    check("fdone_on_video_eop", 32'(fd_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
